// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selector encodings, receiver/transmitter
// state encoding and the parity helper used by both directions.
package uart_pkg;

    // parity_sel encodings; 2'd3 decodes as odd, same as 2'd2
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity bit a correct frame carries: XOR of the data for even,
    // its complement for odd (selector bit 1 set).
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] sel);
        return (^data) ^ sel[1];
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous UART input line.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic mclk,
    input  logic n_reset,
    input  logic din,
    output logic dout
);

    logic meta;

    // Resynchronize the line; both flops reset to the idle level.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, optional even/odd parity, 1 or 2 stop bits,
// mid-bit sampling driven by a programmable bit-period counter.
module uart_rx
    import uart_pkg::*;
(
    input  logic        mclk,
    input  logic        n_reset,
    input  logic [15:0] baudrate,
    input  logic [1:0]  parity_sel,
    input  logic        stop_sel,
    input  logic        rxd,
    output logic [7:0]  rdata,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    logic        rxd_s;
    logic        rxd_prev;
    uart_state_e state;
    logic [15:0] baud_q;
    logic [1:0]  par_q;
    logic        stop_q;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [7:0]  shreg;
    logic        perr_q;
    logic        ferr_q;
    logic        start_edge;
    logic        half_tick;
    logic        bit_tick;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .mclk    (mclk),
        .n_reset (n_reset),
        .din     (rxd),
        .dout    (rxd_s)
    );

    assign start_edge = rxd_prev & ~rxd_s;
    assign half_tick  = (cnt == (baud_q >> 1));
    assign bit_tick   = (cnt == baud_q);

    // Previous synchronized level, for falling-edge detection.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) rxd_prev <= 1'b1;
        else          rxd_prev <= rxd_s;
    end

    // Receive FSM with its counters, shift register and registered outputs.
    // NOTE: every flop here uses non-blocking assignment so all state updates
    // see the pre-edge values of each other, whatever the statement order.
    always_ff @(posedge mclk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_IDLE;
            baud_q     <= '0;
            par_q      <= PAR_NONE;
            stop_q     <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rdata      <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state  <= ST_START;
                        busy   <= 1'b1;
                        baud_q <= baudrate;
                        par_q  <= parity_sel;
                        stop_q <= stop_sel;
                        // The cycle that saw the edge already counts as
                        // cycle 0 of the start bit.
                        cnt    <= 16'd1;
                    end
                end
                ST_START: begin
                    if (half_tick) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state    <= (par_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                            stop_idx <= 1'b0;
                            perr_q   <= 1'b0;
                            ferr_q   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        cnt    <= '0;
                        perr_q <= (rxd_s != parity_bit(shreg, par_q));
                        state  <= ST_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (!rxd_s) ferr_q <= 1'b1;
                        if (stop_idx == stop_q) begin
                            // Last stop sample: publish the frame and go idle
                            // at mid-stop so a following start edge is caught.
                            rdata      <= shreg;
                            parity_err <= perr_q;
                            frame_err  <= ferr_q | ~rxd_s;
                            rx_valid   <= 1'b1;
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
